addsub_pipe: RTL
================

# addsub_pipe

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes and a signed/unsigned status flag set. It generalises the team's combinational 2-bit CLA cell into a WIDTH-bit datapath built from BLOCK-bit lookahead groups, with one pipeline stage per group. It is the arithmetic core of the 8-bit add/sub unit and sits between the operand register file and the result writeback stage.

## Interface
- WIDTH, 8: operand/result width; must be a multiple of BLOCK; elaboration fails otherwise.
- BLOCK, 4: lookahead group width; NSTG = WIDTH/BLOCK pipeline stages.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (op=0) / borrow-in (op=1).
- op  in  1  0 = a+b+cin, 1 = a-b-cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  result.
- cout  out  1  carry-out; for op=1, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.
- neg  out  1  s[WIDTH-1].
- sat  out  1  saturation applied (0 when ADDSUB_SAT_EN is not defined).

## Operation
- Beat accepted when in_valid && in_ready. Effective B = op ? ~b : b; effective carry-in = cin ^ op.
- Stage k (0..NSTG-1) computes bits [k*BLOCK +: BLOCK] with group generate/propagate lookahead from the carry registered by stage k-1 (stage 0 uses the effective carry-in). Unconsumed higher operand bits, op and completed lower sum bits are carried forward in pipeline registers.
- The last stage produces cout = carry out of the MSB and ovf = carry into MSB ^ carry out of MSB. Flags are computed on the final s (after any saturation).
- Flow control is a single global stall: stall = out_valid && !out_ready. When stalled, all stage registers hold. in_ready = !stall (combinational from out_valid/out_ready). Bubbles are not compressed.
- Per-stage valid bits shift with the data. A beat never duplicates or drops under any in_valid/out_ready pattern.
- Reset (rst_n low, any time including mid-flight) clears all valid bits and all data/flag registers. Outputs go to 0 immediately. In-flight beats are discarded. in_ready is 1 once out_valid = 0.

## Timing
- Latency: NSTG cycles from acceptance to out_valid with no stall (WIDTH=8, BLOCK=4: 2 cycles). With BLOCK=WIDTH the latency is 1.
- Throughput: one beat per cycle while out_ready=1.
- s and all flags are registered and stable while out_valid=1 and out_ready=0.
- Simultaneous in_valid and stall: input is not accepted; upstream holds it.
- Reset values: out_valid=0, s=0, cout=0, ovf=0, zero=0, neg=0, sat=0.

## Configuration
- ADDSUB_SAT_EN defined: the last stage applies signed saturation. On ovf with result MSB=0 (negative overflow), s=100..0. On ovf with MSB=1, s=011..1. sat=1 for that beat. ovf still reports 1. cout is unchanged.
- Not defined: the result wraps modulo 2^WIDTH and sat is tied 0. Ports are identical in both builds and latency is unchanged.

## Test plan
- WIDTH=8, BLOCK=4, out_ready=1: a=0x3C, b=0x05, op=0, cin=1 -> 2 cycles later s=0x42, cout=0, ovf=0, zero=0.
- Carry across group boundary: a=0x0F, b=0x01, op=0, cin=0 -> s=0x10. Then a=0xFF, b=0x01 -> s=0x00, cout=1, zero=1.
- Subtract with overflow: a=0x80, b=0x01, op=1, cin=0 -> without macro s=0x7F, cout=1, ovf=1. With ADDSUB_SAT_EN s=0x80, sat=1, neg=1.
- Backpressure: stream 4 beats back-to-back with out_ready low for cycles 3–5 -> in_ready low during the stall, all 4 results delivered in order, none lost or repeated, s stable while stalled.
- Reset mid-flight: accept 2 beats, drop rst_n before either emerges -> out_valid=0 and all outputs 0 immediately. After release no stale beat appears, and a new beat returns correctly after 2 cycles.
- Parameter sweep: BLOCK=8 (1-cycle latency) and WIDTH=16/BLOCK=4 (4-cycle latency), random a/b/op/cin checked against a behavioural model.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor, one BLOCK-bit group per stage,
// valid/ready flow control with a global stall. Define ADDSUB_SAT_EN for signed saturation.
module addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             sat
);

    localparam int NSTG = WIDTH / BLOCK;

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Carries of one lookahead group: c[j+1] = G[j:0] | P[j:0] & c0.
    function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] x,
                                                   input logic [BLOCK-1:0] y,
                                                   input logic             c0);
        logic [BLOCK:0] c;
        logic           gen;
        logic           prop;
        c    = '0;
        c[0] = c0;
        for (int j = 0; j < BLOCK; j++) begin
            gen  = 1'b0;
            prop = 1'b1;
            for (int i = j; i >= 0; i--) begin
                gen  = gen | (prop & x[i] & y[i]);
                prop = prop & (x[i] ^ y[i]);
            end
            c[j+1] = gen | (prop & c0);
        end
        return c;
    endfunction

    // Stage k registers hold the unconsumed operand bits (shifted down), the partial
    // sum (filled from the top), the group carry-out and the stage valid.
    logic             v_q [NSTG];
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic             c_q [NSTG];
    logic             ovf_q, zero_q, neg_q, sat_q;

    logic             vld_in [NSTG];
    logic [WIDTH-1:0] a_in [NSTG];
    logic [WIDTH-1:0] b_in [NSTG];
    logic [WIDTH-1:0] s_in [NSTG];
    logic             c_in [NSTG];

    logic [WIDTH-1:0] a_d [NSTG];
    logic [WIDTH-1:0] b_d [NSTG];
    logic [WIDTH-1:0] s_d [NSTG];
    logic             c_d [NSTG];
    logic             ovf_d, zero_d, neg_d, sat_d;

    logic [BLOCK:0]   cy;
    logic [BLOCK-1:0] grp_sum;
    logic [WIDTH-1:0] grp_ext;
    logic [WIDTH-1:0] s_raw;
    logic [WIDTH-1:0] s_fin;
    logic             stall;

    assign out_valid = v_q[NSTG-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // NOTE: every variable gets a default before any conditional path so no latch is inferred.
    always_comb begin
        ovf_d   = 1'b0;
        zero_d  = 1'b0;
        neg_d   = 1'b0;
        sat_d   = 1'b0;
        cy      = '0;
        grp_sum = '0;
        grp_ext = '0;
        s_raw   = '0;
        s_fin   = '0;

        vld_in[0] = in_valid;
        a_in[0]   = a;
        b_in[0]   = op ? ~b : b;
        c_in[0]   = cin ^ op;
        s_in[0]   = '0;
        for (int k = 1; k < NSTG; k++) begin
            vld_in[k] = v_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            c_in[k]   = c_q[k-1];
            s_in[k]   = s_q[k-1];
        end

        for (int k = 0; k < NSTG; k++) begin
            cy      = cla_carries(a_in[k][BLOCK-1:0], b_in[k][BLOCK-1:0], c_in[k]);
            grp_sum = a_in[k][BLOCK-1:0] ^ b_in[k][BLOCK-1:0] ^ cy[BLOCK-1:0];
            grp_ext = '0;
            grp_ext[BLOCK-1:0] = grp_sum;
            a_d[k]  = a_in[k] >> BLOCK;
            b_d[k]  = b_in[k] >> BLOCK;
            c_d[k]  = cy[BLOCK];
            s_raw   = (s_in[k] >> BLOCK) | (grp_ext << (WIDTH - BLOCK));
            s_fin   = s_raw;
            if (k == NSTG - 1) begin
                ovf_d = cy[BLOCK-1] ^ cy[BLOCK];
`ifdef ADDSUB_SAT_EN
                // Wrapped MSB of 0 means the true result fell below the signed minimum.
                if (ovf_d) begin
                    sat_d = 1'b1;
                    s_fin = {~s_raw[WIDTH-1], {(WIDTH-1){s_raw[WIDTH-1]}}};
                end
`endif
                zero_d = (s_fin == '0);
                neg_d  = s_fin[WIDTH-1];
            end
            s_d[k] = s_fin;
        end
    end

    // NOTE: the stage arrays are ordinary flops, so they are reset along with the valids;
    // <= makes every stage sample its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < NSTG; k++) begin
                v_q[k] <= vld_in[k];
                if (vld_in[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (vld_in[NSTG-1]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                neg_q  <= neg_d;
                sat_q  <= sat_d;
            end
        end
    end

    assign s    = s_q[NSTG-1];
    assign cout = c_q[NSTG-1];
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign neg  = neg_q;
    assign sat  = sat_q;

endmodule
